// File: rtl/mem_bus_master_if.sv
// Shared ifa memory bus. Each agent drives data through its own enable; the
// interface resolves the single data bus so only one side ever drives it.
interface ifa;
  logic       gnt;
  logic [1:0] mode;
  logic [7:0] addr;
  logic       req;
  logic       start;
  logic       rdy;
  logic [7:0] m_data;
  logic       m_data_oe;
  logic [7:0] s_data;
  logic       s_data_oe;
  logic [7:0] data;

  assign data = m_data_oe ? m_data : (s_data_oe ? s_data : 'z);

  modport master (
    output gnt, mode, addr, req, start, rdy, m_data, m_data_oe,
    input  data
  );

  modport slave (
    input  gnt, mode, addr, req, start, rdy, data,
    output s_data, s_data_oe
  );
endinterface

// File: rtl/mem_bus_master.sv
// Upstream bus master: buffers read/write commands in a FIFO and runs one
// ifa transaction per command (ACCESS cycle, then a one-cycle turnaround GAP).
module mem_bus_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       cmd_err,
  ifa.master         bus
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [8:0]  LP_WORDS = 9'(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_GAP} state_t;

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  cmd_t          r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  cmd_t          r_cur;
  state_t        r_state;
  state_t        w_next;
  logic          r_rsp_valid;
  logic [7:0]    r_rsp_rdata;
  logic          r_err;

  logic w_full, w_empty, w_accept, w_legal, w_push, w_pop;

  assign w_full   = (r_count == LP_FULL);
  assign w_empty  = (r_count == '0);
  assign w_accept = cmd_valid && !w_full;
  assign w_legal  = ({1'b0, cmd_addr} < LP_WORDS);
  assign w_push   = w_accept && w_legal;
  // Head is popped on the edge that enters ACCESS, from IDLE or straight from GAP.
  assign w_pop    = !w_empty && (r_state != S_ACCESS);

  assign cmd_ready = !w_full;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign cmd_err   = r_err;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_cur   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_cur  <= r_fifo[r_rptr];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= (r_state == S_ACCESS) && !r_cur.write;
      if ((r_state == S_ACCESS) && !r_cur.write) r_rsp_rdata <= bus.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (!w_empty) w_next = S_ACCESS;
      S_ACCESS: w_next = S_GAP;
      S_GAP:    w_next = w_empty ? S_IDLE : S_ACCESS;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus outputs decode from state so reset drops gnt and data asynchronously.
  always_comb begin
    bus.gnt       = 1'b0;
    bus.mode      = 2'b00;
    bus.addr      = '0;
    bus.start     = 1'b0;
    bus.rdy       = 1'b0;
    bus.m_data    = '0;
    bus.m_data_oe = 1'b0;
    bus.req       = !w_empty;
    unique case (r_state)
      S_ACCESS: begin
        bus.gnt       = 1'b1;
        bus.mode      = {1'b0, r_cur.write};
        bus.addr      = r_cur.addr;
        bus.start     = 1'b1;
        bus.m_data    = r_cur.write ? r_cur.wdata : '0;
        bus.m_data_oe = r_cur.write;
      end
      S_GAP:   bus.rdy = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a 32-word memory slave on the ifa bus.
module tb_mem_bus_master;
  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;

  ifa bus();

  mem_bus_master #(.FIFO_DEPTH(4), .MEM_WORDS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .cmd_err   (cmd_err),
    .bus       (bus)
  );

  // Memory slave: captures writes at the closing edge of ACCESS, drives reads.
  logic [7:0] smem [32];
  always_ff @(posedge clk) begin
    if (bus.gnt && bus.mode == 2'b01) smem[bus.addr[4:0]] <= bus.data;
  end
  assign bus.s_data    = smem[bus.addr[4:0]];
  assign bus.s_data_oe = bus.gnt && (bus.mode == 2'b00);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic idle_in();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
  endtask

  logic       exp_rdy [19];
  logic       exp_g;
  logic       acc;
  int         nsent;
  int         nrsp;
  logic [7:0] rsp_seen [4];

  initial begin
    rst_n = 1'b0;
    idle_in();
    exp_rdy = '{1,1,1,1,1,1,1,0,1,0,1,1,1,1,1,1,1,1,1};
    repeat (2) step();
    chk("rst_gnt",   bus.gnt, 0);
    chk("rst_mode",  bus.mode, 0);
    chk("rst_addr",  bus.addr, 0);
    chk("rst_req",   bus.req, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_rdy",   bus.rdy, 0);
    chk("rst_oe",    bus.m_data_oe, 0);
    chk("rst_rspv",  rsp_valid, 0);
    chk("rst_rspd",  rsp_rdata, 0);
    chk("rst_err",   cmd_err, 0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", cmd_ready, 1);

    // Write 5 <= A5 then read 5.
    drive(1'b1, 8'd5, 8'hA5);
    step();
    chk("wr_req",    bus.req, 1);
    chk("wr_idle",   bus.gnt, 0);
    drive(1'b0, 8'd5, 8'h00);
    step();
    idle_in();
    chk("wr_gnt",    bus.gnt, 1);
    chk("wr_mode",   bus.mode, 1);
    chk("wr_addr",   bus.addr, 5);
    chk("wr_start",  bus.start, 1);
    chk("wr_oe",     bus.m_data_oe, 1);
    chk("wr_data",   bus.data, 8'hA5);
    step();
    chk("gap_gnt",   bus.gnt, 0);
    chk("gap_rdy",   bus.rdy, 1);
    chk("gap_oe",    bus.m_data_oe, 0);
    step();
    chk("rd_gnt",    bus.gnt, 1);
    chk("rd_mode",   bus.mode, 0);
    chk("rd_addr",   bus.addr, 5);
    chk("rd_oe",     bus.m_data_oe, 0);
    chk("rd_req",    bus.req, 0);
    step();
    chk("rd_rspv",   rsp_valid, 1);
    chk("rd_rspd",   rsp_rdata, 8'hA5);
    step();
    chk("rd_rspv_end", rsp_valid, 0);
    chk("rd_hold",   rsp_rdata, 8'hA5);
    chk("rd_done",   bus.gnt, 0);

    // Eight writes pushed back-to-back: FIFO fills, executes every 2 cycles.
    nsent = 0;
    for (int k = 0; k < 19; k++) begin
      chk("fill_ready", cmd_ready, exp_rdy[k]);
      exp_g = (k % 2 == 0) && (k >= 2) && (k <= 16);
      chk("fill_gnt", bus.gnt, exp_g);
      if (exp_g) begin
        chk("fill_addr", bus.addr, 10 + (k - 2) / 2);
        chk("fill_data", bus.data, 8'h30 + (k - 2) / 2);
      end
      chk("fill_rdy", bus.rdy, (k % 2 == 1) && (k >= 3) && (k <= 17));
      if (nsent < 8) drive(1'b1, 8'(10 + nsent), 8'(8'h30 + nsent));
      else           idle_in();
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) nsent++;
    end
    idle_in();
    chk("fill_sent", nsent, 8);

    // Out-of-range address is rejected; the next legal read proceeds.
    drive(1'b1, 8'd40, 8'h55);
    step();
    chk("bad_err",   cmd_err, 1);
    chk("bad_req",   bus.req, 0);
    chk("bad_gnt",   bus.gnt, 0);
    drive(1'b0, 8'd12, 8'h00);
    step();
    idle_in();
    chk("bad_err_end", cmd_err, 0);
    chk("bad_gnt2",  bus.gnt, 0);
    chk("nxt_req",   bus.req, 1);
    step();
    chk("nxt_gnt",   bus.gnt, 1);
    chk("nxt_addr",  bus.addr, 12);
    step();
    chk("nxt_rspv",  rsp_valid, 1);
    chk("nxt_rspd",  rsp_rdata, 8'h32);
    step();

    // Boundary addresses 0 and 31.
    nrsp = 0;
    for (int k = 0; k < 16; k++) begin
      if (rsp_valid) begin
        if (nrsp < 4) rsp_seen[nrsp] = rsp_rdata;
        nrsp++;
      end
      if (bus.gnt && bus.mode == 2'b00) chk("bnd_rd_oe", bus.m_data_oe, 0);
      case (k)
        0: drive(1'b1, 8'd0,  8'h11);
        1: drive(1'b1, 8'd31, 8'h22);
        2: drive(1'b0, 8'd0,  8'h00);
        3: drive(1'b0, 8'd31, 8'h00);
        default: idle_in();
      endcase
      step();
    end
    chk("bnd_nrsp", nrsp, 2);
    chk("bnd_rsp0", rsp_seen[0], 8'h11);
    chk("bnd_rsp1", rsp_seen[1], 8'h22);

    // Reset during a read ACCESS with two commands still queued.
    drive(1'b0, 8'd0, 8'h00);  step();
    drive(1'b0, 8'd5, 8'h00);  step();
    drive(1'b0, 8'd12, 8'h00); step();
    drive(1'b0, 8'd31, 8'h00); step();
    idle_in();
    chk("mid_gnt",   bus.gnt, 1);
    chk("mid_addr",  bus.addr, 5);
    chk("mid_req",   bus.req, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt",   bus.gnt, 0);
    chk("mid_rst_start", bus.start, 0);
    chk("mid_rst_oe",    bus.m_data_oe, 0);
    chk("mid_rst_req",   bus.req, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_rst_rspv", rsp_valid, 0);
    end
    rst_n = 1'b1;
    step();
    chk("post_req",   bus.req, 0);
    chk("post_ready", cmd_ready, 1);
    chk("post_gnt",   bus.gnt, 0);
    chk("post_rspv",  rsp_valid, 0);

    // Idle bus with no commands.
    for (int k = 0; k < 20; k++) begin
      step();
      chk("idle_gnt",  bus.gnt, 0);
      chk("idle_req",  bus.req, 0);
      chk("idle_oe",   bus.m_data_oe, 0);
      chk("idle_rspv", rsp_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
